data_mem_responder: RTL

Synthesizable responder for the pipeline's data-memory port. It answers the datapath's `data_mem_read` / `data_mem_write` requests after a programmable latency, with a one-cycle `mem_resp` pulse, using a word-addressed register-array store with per-byte write enables. It sits across the port from the datapath's data-side initiator. It stands in for the data cache in bring-up and in multi-cycle-memory stall testing.

---
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Stand-in for the data cache on the pipeline's data-memory port. Accepts one
// read or write request, waits LATENCY cycles, then completes it with a single
// mem_resp pulse. Storage is a word-addressed register array with per-byte
// write enables.
//
// Parameters
//   DEPTH_LOG2  log2 of the number of 32-bit words stored
//   LATENCY     cycles from acceptance to mem_resp (1..15)
//
// Ports
//   clk              sole clock, rising edge
//   rst              asynchronous active-low reset
//   mem_read         read request, held by the initiator until mem_resp
//   mem_write        write request, held by the initiator until mem_resp
//   mem_byte_enable  write lane mask, bit i covers mem_wdata[8i+7:8i]
//   mem_address      byte address; word index is address[DEPTH_LOG2+1:2]
//   mem_wdata        lane-aligned write data
//   mem_rdata        registered read data, updated only by reads
//   mem_resp         one-cycle completion pulse
//   busy             high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end

  // The WAIT counter counts down to zero, so one cycle of latency is spent in
  // IDLE->WAIT and one in WAIT->RESP; hence the load value of LATENCY-2.
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    accept;

  logic                    op_write_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;

  logic                    eff_write;
  logic [DEPTH_LOG2-1:0]   eff_idx;
  logic [31:0]             eff_wdata;
  logic [3:0]              eff_be;
  logic                    enter_resp;

  logic [31:0]             mem [DEPTH];

  // Only the word index takes part in addressing; the rest aliases away.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[31:DEPTH_LOG2+2], mem_address[1:0]};

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the array/rdata update happens on the acceptance edge, so
  // the live inputs are used then; in every later cycle only the captured
  // copies matter. Write wins over a simultaneous read.
  assign eff_write  = accept ? mem_write                       : op_write_q;
  assign eff_idx    = accept ? mem_address[DEPTH_LOG2+1:2]     : idx_q;
  assign eff_wdata  = accept ? mem_wdata                       : wdata_q;
  assign eff_be     = accept ? mem_byte_enable                 : be_q;
  assign enter_resp = (state_nxt == RESP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      mem_rdata  <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op_write_q <= mem_write;
        idx_q      <= mem_address[DEPTH_LOG2+1:2];
        wdata_q    <= mem_wdata;
        be_q       <= mem_byte_enable;
      end
      if (enter_resp && !eff_write) mem_rdata <= mem[eff_idx];
    end
  end

  // NOTE: the storage array is deliberately not reset; contents are undefined
  // until written. The rst term blocks a commit while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && eff_write) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_be[i]) mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
      end
    end
  end

  assign mem_resp = (state == RESP);
  assign busy     = (state != IDLE);

endmodule
